// File: rtl/serial_sub.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first, with a start/done handshake.
// Optional signed-overflow output ovf is built only when SERIAL_SUB_OVF_EN is defined.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a0, b0, diff, br_nx, last, accept;
`ifdef SERIAL_SUB_OVF_EN
    logic             amsb, bmsb;
`endif

    always_comb begin
        a0       = sa[0];
        b0       = sb[0];
        diff     = a0 ^ b0 ^ br;
        br_nx    = (~a0 & b0) | (~(a0 ^ b0) & br);
        last     = (cnt == CW'(WIDTH - 1));
        accept   = (state != S_RUN) && start;
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last) state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_RUN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            d    <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            amsb <= 1'b0;
            bmsb <= 1'b0;
            ovf  <= 1'b0;
`endif
        end else begin
            busy <= (state_nx == S_RUN);
            done <= (state == S_RUN) && last;
            if (accept) begin
                // d/bout/ovf keep the previous result until this operation completes
                sa  <= a;
                sb  <= b;
                br  <= bin;
                cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                amsb <= a[WIDTH-1];
                bmsb <= b[WIDTH-1];
`endif
            end else if (state == S_RUN) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                br  <= br_nx;
                res <= {diff, res[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
                if (last) begin
                    d    <= {diff, res[WIDTH-1:1]};
                    bout <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
                    ovf  <= (amsb != bmsb) && (diff != amsb);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): arithmetic reference model plus directed literal checks.
// Build with SERIAL_SUB_OVF_EN defined to also check the ovf output.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] d;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    serial_sub #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .d    (d),
        .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: result from plain integer arithmetic, delivered W edges after acceptance
    logic         m_busy = 1'b0, m_done = 1'b0, m_bout = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_d = '0;
    logic [W-1:0] p_d;
    logic         p_bout, p_ovf;
    int           m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_d = '0; m_bout = 1'b0; m_ovf = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    m_d = p_d; m_bout = p_bout; m_ovf = p_ovf;
                end
            end else if (start) begin
                int r, s;
                r = int'(a) - int'(b) - int'(bin);
                s = int'($signed(a)) - int'($signed(b)) - int'(bin);
                p_d    = W'(r);
                p_bout = (r < 0);
                p_ovf  = (s < -(2 ** (W - 1))) || (s > 2 ** (W - 1) - 1);
                m_left = W;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({busy, done, bout, d} !== {m_busy, m_done, m_bout, m_d}) begin
                errors++;
                $display("FAIL cycle t=%0t busy/done/bout/d got %b %b %b %h expected %b %b %b %h",
                         $time, busy, done, bout, d, m_busy, m_done, m_bout, m_d);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ovf !== m_ovf) begin
                errors++;
                $display("FAIL cycle_ovf t=%0t got %b expected %b", $time, ovf, m_ovf);
            end
`endif
        end
    end

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                          input logic [W-1:0] ed, input logic eb, input logic eo, input string nm);
        logic got;
        @(negedge clk);
        a = xa; b = xb; bin = xbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got || d !== ed || bout !== eb) begin
            errors++;
            $display("FAIL %s got done=%b d=%h bout=%b expected done=1 d=%h bout=%b", nm, got, d, bout, ed, eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== eo) begin
            errors++;
            $display("FAIL %s_ovf got %b expected %b", nm, ovf, eo);
        end
`else
        if (eo) begin end
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int first, second, ndone;
        logic [W-1:0] d_first;
        logic b_first;

        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, bout, d} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b bout=%b d=%h expected all zero", busy, done, bout, d);
        end
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "sub_5_3");
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "sub_3_5");
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_0_0_bin");
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "sub_80_01");
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "sub_7f_ff");
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "sub_10_01");
        run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, "sub_80_7f_bin");

        // Start held high: operand changes while busy must be ignored; back-to-back every W+1 cycles
        @(negedge clk);
        a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
        first = 0; second = 0; d_first = '0; b_first = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            b = (i == 3 || i == 5) ? 8'h00 : 8'h04;
            if (done) begin
                if (first == 0) begin
                    first = i; d_first = d; b_first = bout;
                end else begin
                    second = i;
                    break;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (first != W + 1 || second != 2 * W + 2 || d_first !== 8'h05 || b_first !== 1'b0) begin
            errors++;
            $display("FAIL handshake got done@%0d,%0d d=%h bout=%b expected done@%0d,%0d d=05 bout=0",
                     first, second, d_first, b_first, W + 1, 2 * W + 2);
        end
        repeat (2) @(negedge clk);

        // Reset abort mid-operation
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bout, d} !== '0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b done=%b bout=%b d=%h expected all zero", busy, done, bout, d);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done pulses expected 0", ndone);
        end
        run_op(8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0, "after_abort");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
